// File: rtl/ctrl_pkg.sv
`default_nettype none
// =============================================================================
// ctrl_pkg : shared control encodings, widths and the E-stage control bundle.
// Revision : 1.0
// =============================================================================
package ctrl_pkg;

  localparam int ALUCTRL_W = 3;
  localparam int RD_W      = 5;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // Field order matches the ID/EX register layout in ctrl_pipe_regs.
  typedef struct packed {
    logic                 valid;
    logic                 reg_write;
    logic [1:0]           result_src;
    logic                 mem_write;
    logic                 jump;
    logic                 branch;
    logic [ALUCTRL_W-1:0] alu_control;
    logic                 alu_src;
    logic [RD_W-1:0]      rd;
  } ctrl_e_t;

endpackage
`default_nettype wire

// File: rtl/ctrl_pipe_regs_if.sv
`default_nettype none
// =============================================================================
// ctrl_pipe_regs_if : decoded controls in, per-stage controls and counter out.
// Revision : 1.0
// =============================================================================
interface ctrl_pipe_regs_if #(
  parameter int ALUCTRL_W = ctrl_pkg::ALUCTRL_W,
  parameter int RD_W      = ctrl_pkg::RD_W,
  parameter int CNT_W     = 32
);
  logic                 valid_d;
  logic                 reg_write_d;
  logic [1:0]           result_src_d;
  logic                 mem_write_d;
  logic                 jump_d;
  logic                 branch_d;
  logic [ALUCTRL_W-1:0] alu_control_d;
  logic                 alu_src_d;
  logic [RD_W-1:0]      rd_d;
  logic                 flush_e;
  logic                 zero_e;

  logic                 reg_write_e;
  logic [1:0]           result_src_e;
  logic                 mem_write_e;
  logic                 jump_e;
  logic                 branch_e;
  logic [ALUCTRL_W-1:0] alu_control_e;
  logic                 alu_src_e;
  logic [RD_W-1:0]      rd_e;
  logic                 valid_e;
  logic                 pc_src_e;

  logic                 reg_write_m;
  logic [1:0]           result_src_m;
  logic                 mem_write_m;
  logic [RD_W-1:0]      rd_m;
  logic                 valid_m;

  logic                 reg_write_w;
  logic [1:0]           result_src_w;
  logic [RD_W-1:0]      rd_w;
  logic                 valid_w;

  logic [CNT_W-1:0]     instret;

  modport master (
    output valid_d, reg_write_d, result_src_d, mem_write_d, jump_d, branch_d,
           alu_control_d, alu_src_d, rd_d, flush_e, zero_e,
    input  reg_write_e, result_src_e, mem_write_e, jump_e, branch_e,
           alu_control_e, alu_src_e, rd_e, valid_e, pc_src_e,
           reg_write_m, result_src_m, mem_write_m, rd_m, valid_m,
           reg_write_w, result_src_w, rd_w, valid_w, instret
  );

  modport slave (
    input  valid_d, reg_write_d, result_src_d, mem_write_d, jump_d, branch_d,
           alu_control_d, alu_src_d, rd_d, flush_e, zero_e,
    output reg_write_e, result_src_e, mem_write_e, jump_e, branch_e,
           alu_control_e, alu_src_e, rd_e, valid_e, pc_src_e,
           reg_write_m, result_src_m, mem_write_m, rd_m, valid_m,
           reg_write_w, result_src_w, rd_w, valid_w, instret
  );

endinterface
`default_nettype wire

// File: rtl/ctrl_stage_reg.sv
`default_nettype none
// =============================================================================
// ctrl_stage_reg : pipeline register with async active-low and sync clear.
// Revision : 1.0
// =============================================================================
module ctrl_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] data_d;
  logic [W-1:0] data_q;

  always_comb begin
    data_d = d;
    if (clr) data_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign q = data_q;

endmodule
`default_nettype wire

// File: rtl/ctrl_pipe_regs.sv
`default_nettype none
// =============================================================================
// ctrl_pipe_regs : carries decoded controls through ID/EX, EX/MEM and MEM/WB,
//                  derives PCSrcE and counts retired instructions.
// Revision : 1.0
// =============================================================================
module ctrl_pipe_regs #(
  parameter int ALUCTRL_W = ctrl_pkg::ALUCTRL_W,
  parameter int RD_W      = ctrl_pkg::RD_W,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  ctrl_pipe_regs_if.slave  bus
);
  import ctrl_pkg::*;

  localparam int E_W = 8 + ALUCTRL_W + RD_W;
  localparam int M_W = 5 + RD_W;
  localparam int W_W = 4 + RD_W;

  logic [E_W-1:0]   e_in, e_out;
  logic [M_W-1:0]   m_in, m_out;
  logic [W_W-1:0]   w_in, w_out;
  logic [CNT_W-1:0] instret_d, instret_q;

  // Same field order as ctrl_e_t so the bundle can be swapped for the struct.
  assign e_in = {bus.valid_d, bus.reg_write_d, bus.result_src_d, bus.mem_write_d,
                 bus.jump_d, bus.branch_d, bus.alu_control_d, bus.alu_src_d,
                 bus.rd_d};

  ctrl_stage_reg #(.W(E_W)) u_id_ex (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.flush_e),
    .d     (e_in),
    .q     (e_out)
  );

  assign {bus.valid_e, bus.reg_write_e, bus.result_src_e, bus.mem_write_e,
          bus.jump_e, bus.branch_e, bus.alu_control_e, bus.alu_src_e,
          bus.rd_e} = e_out;

  // A flush kills only the incoming slot; the taken branch still redirects.
  assign bus.pc_src_e = (bus.branch_e & bus.zero_e) | bus.jump_e;

  assign m_in = {bus.valid_e, bus.reg_write_e, bus.result_src_e,
                 bus.mem_write_e, bus.rd_e};

  ctrl_stage_reg #(.W(M_W)) u_ex_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .d     (m_in),
    .q     (m_out)
  );

  assign {bus.valid_m, bus.reg_write_m, bus.result_src_m, bus.mem_write_m,
          bus.rd_m} = m_out;

  assign w_in = {bus.valid_m, bus.reg_write_m, bus.result_src_m, bus.rd_m};

  ctrl_stage_reg #(.W(W_W)) u_mem_wb (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .d     (w_in),
    .q     (w_out)
  );

  assign {bus.valid_w, bus.reg_write_w, bus.result_src_w, bus.rd_w} = w_out;

  always_comb begin
    instret_d = instret_q + {{(CNT_W-1){1'b0}}, bus.valid_w};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) instret_q <= '0;
    else        instret_q <= instret_d;
  end

  assign bus.instret = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe_regs.sv
`default_nettype none
// =============================================================================
// tb_ctrl_pipe_regs : directed stimulus with a W-stage scoreboard, run against
//                     a 32-bit-counter and a 4-bit-counter build in parallel.
// Revision : 1.0
// =============================================================================
module tb_ctrl_pipe_regs;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       valid_d = 0, reg_write_d = 0, mem_write_d = 0, jump_d = 0;
  logic       branch_d = 0, alu_src_d = 0, flush_e = 0, zero_e = 0;
  logic [1:0] result_src_d = 0;
  logic [2:0] alu_control_d = 0;
  logic [4:0] rd_d = 0;

  ctrl_pipe_regs_if #(.ALUCTRL_W(3), .RD_W(5), .CNT_W(32)) bus32 ();
  ctrl_pipe_regs_if #(.ALUCTRL_W(3), .RD_W(5), .CNT_W(4))  bus4 ();

  assign bus32.valid_d = valid_d;         assign bus4.valid_d = valid_d;
  assign bus32.reg_write_d = reg_write_d; assign bus4.reg_write_d = reg_write_d;
  assign bus32.result_src_d = result_src_d; assign bus4.result_src_d = result_src_d;
  assign bus32.mem_write_d = mem_write_d; assign bus4.mem_write_d = mem_write_d;
  assign bus32.jump_d = jump_d;           assign bus4.jump_d = jump_d;
  assign bus32.branch_d = branch_d;       assign bus4.branch_d = branch_d;
  assign bus32.alu_control_d = alu_control_d; assign bus4.alu_control_d = alu_control_d;
  assign bus32.alu_src_d = alu_src_d;     assign bus4.alu_src_d = alu_src_d;
  assign bus32.rd_d = rd_d;               assign bus4.rd_d = rd_d;
  assign bus32.flush_e = flush_e;         assign bus4.flush_e = flush_e;
  assign bus32.zero_e = zero_e;           assign bus4.zero_e = zero_e;

  ctrl_pipe_regs #(.ALUCTRL_W(3), .RD_W(5), .CNT_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .bus(bus32)
  );
  ctrl_pipe_regs #(.ALUCTRL_W(3), .RD_W(5), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] sb[$];   // {reg_write, result_src[1:0], rd[4:0]} expected in W

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic issue(input logic v, input logic rw, input logic [1:0] rs,
                       input logic mw, input logic j, input logic b,
                       input logic [2:0] alu, input logic as,
                       input logic [4:0] rd, input logic fl);
    valid_d = v; reg_write_d = rw; result_src_d = rs; mem_write_d = mw;
    jump_d = j; branch_d = b; alu_control_d = alu; alu_src_d = as;
    rd_d = rd; flush_e = fl;
    if (v && !fl) sb.push_back({rw, rs, rd});
    @(posedge clk); #1;
  endtask

  task automatic nop();
    issue(0, 0, 2'b00, 0, 0, 0, 3'd0, 0, 5'd0, 0);
  endtask

  task automatic drain();
    repeat (4) nop();
  endtask

  // Monitor: every valid W slot must match the oldest outstanding expectation.
  logic [7:0] exp_w;
  initial begin
    forever begin
      @(posedge clk); #2;
      if (bus32.valid_w === 1'b1) begin
        if (sb.size() == 0) begin
          chk("w_unexpected", 32'd1, 32'd0);
        end else begin
          exp_w = sb.pop_front();
          chk("reg_write_w", {31'd0, bus32.reg_write_w}, {31'd0, exp_w[7]});
          chk("result_src_w", {30'd0, bus32.result_src_w}, {30'd0, exp_w[6:5]});
          chk("rd_w", {27'd0, bus32.rd_w}, {27'd0, exp_w[4:0]});
          chk("valid_w_c4", {31'd0, bus4.valid_w}, 32'd1);
          chk("rd_w_c4", {27'd0, bus4.rd_w}, {27'd0, exp_w[4:0]});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_e", {31'd0, bus32.valid_e}, 32'd0);
    chk("rst_instret", bus32.instret, 32'd0);
    rst_n = 1'b1;

    // Reset mid-stream: asserted between edges, must clear without a clock
    repeat (3) issue(1, 1, 2'b00, 0, 0, 0, 3'd0, 0, 5'd3, 0);
    valid_d = 0; reg_write_d = 0; rd_d = 0;
    #3;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("async_valid_e", {31'd0, bus32.valid_e}, 32'd0);
    chk("async_rd_e", {27'd0, bus32.rd_e}, 32'd0);
    chk("async_valid_m", {31'd0, bus32.valid_m}, 32'd0);
    chk("async_valid_w", {31'd0, bus32.valid_w}, 32'd0);
    chk("async_rd_w", {27'd0, bus32.rd_w}, 32'd0);
    chk("async_instret", bus32.instret, 32'd0);
    #1 rst_n = 1'b1;

    // Single R-type
    issue(1, 1, 2'b00, 0, 0, 0, 3'd0, 0, 5'd5, 0);
    chk("rt_reg_write_e", {31'd0, bus32.reg_write_e}, 32'd1);
    chk("rt_rd_e", {27'd0, bus32.rd_e}, 32'd5);
    chk("rt_valid_e", {31'd0, bus32.valid_e}, 32'd1);
    chk("rt_pc_src_e", {31'd0, bus32.pc_src_e}, 32'd0);
    nop();
    chk("rt_rd_m", {27'd0, bus32.rd_m}, 32'd5);
    chk("rt_valid_m", {31'd0, bus32.valid_m}, 32'd1);
    nop();
    chk("rt_rd_w", {27'd0, bus32.rd_w}, 32'd5);
    chk("rt_valid_w", {31'd0, bus32.valid_w}, 32'd1);
    nop();
    chk("rt_instret", bus32.instret, 32'd1);

    // Load, flushed store (load-use bubble), then the re-issued add
    issue(1, 1, 2'b01, 0, 0, 0, 3'd0, 1, 5'd7, 0);
    issue(1, 0, 2'b00, 1, 0, 0, 3'd2, 1, 5'd9, 1);
    chk("fl_valid_e", {31'd0, bus32.valid_e}, 32'd0);
    chk("fl_mem_write_e", {31'd0, bus32.mem_write_e}, 32'd0);
    chk("fl_alu_control_e", {29'd0, bus32.alu_control_e}, 32'd0);
    chk("fl_rd_e", {27'd0, bus32.rd_e}, 32'd0);
    issue(1, 1, 2'b00, 0, 0, 0, 3'd0, 0, 5'd8, 0);
    chk("fl_valid_m", {31'd0, bus32.valid_m}, 32'd0);
    chk("fl_mem_write_m", {31'd0, bus32.mem_write_m}, 32'd0);
    chk("fl_rd_m", {27'd0, bus32.rd_m}, 32'd0);
    nop();
    chk("fl_valid_w", {31'd0, bus32.valid_w}, 32'd0);
    chk("fl_rd_w", {27'd0, bus32.rd_w}, 32'd0);
    nop();
    nop();
    chk("fl_instret", bus32.instret, 32'd3);

    // beq in E: PCSrcE follows zero_e combinationally
    issue(1, 0, 2'b00, 0, 0, 1, 3'd1, 0, 5'd0, 0);
    zero_e = 1'b1; #1;
    chk("beq_taken", {31'd0, bus32.pc_src_e}, 32'd1);
    zero_e = 1'b0; #1;
    chk("beq_not_taken", {31'd0, bus32.pc_src_e}, 32'd0);
    zero_e = 1'b1; #1;
    chk("beq_flip", {31'd0, bus32.pc_src_e}, 32'd1);
    flush_e = 1'b1; #1;
    chk("beq_flush_pc_src", {31'd0, bus32.pc_src_e}, 32'd1);
    issue(1, 1, 2'b00, 0, 0, 0, 3'd0, 0, 5'd10, 1);
    chk("beq_adv_valid_m", {31'd0, bus32.valid_m}, 32'd1);
    chk("beq_killed_valid_e", {31'd0, bus32.valid_e}, 32'd0);
    zero_e = 1'bx; #1;
    chk("bubble_zero_x", {31'd0, bus32.pc_src_e}, 32'd0);
    zero_e = 1'b0;
    drain();
    chk("beq_instret", bus32.instret, 32'd4);

    // jal
    issue(1, 1, 2'b10, 0, 1, 0, 3'd0, 0, 5'd1, 0);
    zero_e = 1'b0; #1;
    chk("jal_pc_src_z0", {31'd0, bus32.pc_src_e}, 32'd1);
    zero_e = 1'b1; #1;
    chk("jal_pc_src_z1", {31'd0, bus32.pc_src_e}, 32'd1);
    zero_e = 1'b0;
    nop();
    nop();
    chk("jal_result_src_w", {30'd0, bus32.result_src_w}, 32'd2);
    chk("jal_rd_w", {27'd0, bus32.rd_w}, 32'd1);
    drain();
    chk("jal_instret", bus32.instret, 32'd5);
    chk("jal_instret_c4", {28'd0, bus4.instret}, 32'd5);

    // 4-bit counter wrap after 17 retirements
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      issue(1, 1, 2'b00, 0, 0, 0, 3'd0, 0, 5'(i + 1), 0);
    end
    nop();
    chk("wrap_c4_15", {28'd0, bus4.instret}, 32'd15);
    chk("wrap_c32_15", bus32.instret, 32'd15);
    nop();
    chk("wrap_c4_0", {28'd0, bus4.instret}, 32'd0);
    chk("wrap_c32_16", bus32.instret, 32'd16);
    nop();
    chk("wrap_c4_1", {28'd0, bus4.instret}, 32'd1);
    chk("wrap_c32_17", bus32.instret, 32'd17);
    drain();
    chk("sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ctrl_pipe_regs.md
Name: ctrl_pipe_regs

Overview:
- Control-signal pipeline that sits directly downstream of the decode-stage controller in the hazard-free pipelined RV32 core.
- Captures the decoded D-stage controls and destination register, then carries them through the ID/EX, EX/MEM and MEM/WB boundaries.
- Generates PCSrcE from the E-stage branch/jump controls and the ALU zero flag.
- Keeps a per-stage valid bit and a retired-instruction counter for bring-up and performance checks.

Parameters:
- ALUCTRL_W, 3, width of the ALUControl bus.
- RD_W, 5, width of the destination register index.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_d  in  1  a real instruction is in the D stage (0 = bubble).
- reg_write_d  in  1  decoded RegWrite.
- result_src_d  in  2  decoded ResultSrc.
- mem_write_d  in  1  decoded MemWrite.
- jump_d  in  1  decoded Jump.
- branch_d  in  1  decoded Branch (beq semantics only).
- alu_control_d  in  ALUCTRL_W  decoded ALUControl.
- alu_src_d  in  1  decoded ALUSrc.
- rd_d  in  RD_W  destination register of the D-stage instruction.
- flush_e  in  1  turns the next ID/EX contents into a bubble.
- zero_e  in  1  ALU zero flag for the E-stage instruction.
- reg_write_e, result_src_e, mem_write_e, jump_e, branch_e, alu_control_e, alu_src_e, rd_e, valid_e  out  (widths as D)  E-stage controls.
- pc_src_e  out  1  taken branch or jump in E.
- reg_write_m, result_src_m, mem_write_m, rd_m, valid_m  out  (widths as D)  M-stage controls.
- reg_write_w, result_src_w, rd_w, valid_w  out  (widths as D)  W-stage controls.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset: while rst_n = 0, every registered output is 0, including all controls, rd_*, valid_*, and instret. pc_src_e is therefore 0. Reset asserted mid-operation clears all stages immediately and does not wait for a clock edge.
- ID/EX stage, per edge:
  - If flush_e = 1, load a bubble: all E controls 0, rd_e = 0, valid_e = 0.
  - Otherwise load all D inputs.
  - When valid_d = 0, the D controls are still loaded as presented. The decoder drives zeros for a bubble.
- EX/MEM stage: unconditionally loads the E values of reg_write, result_src, mem_write, rd and valid.
- MEM/WB stage: unconditionally loads the M values of reg_write, result_src, rd and valid.
- There is no stall input. A load-use stall is handled upstream by holding F/D and asserting flush_e.
- Latency: inputs sampled at edge k appear on the E outputs after edge k, the M outputs after edge k+1, and the W outputs after edge k+2.
- pc_src_e is combinational: (branch_e & zero_e) | jump_e.
  - No registered path.
  - A bubble in E always gives 0, regardless of an X on zero_e.
- flush_e asserted in the same cycle that E holds a taken branch:
  - pc_src_e is still 1 for that cycle.
  - The branch itself advances to M normally.
  - Only the incoming D instruction is killed.
- instret increments by 1 on each edge where valid_w = 1. It wraps modulo 2^CNT_W with no saturation and no flag.
- A flushed instruction never reaches W with valid = 1, so it is never counted.

Decomposition:
- Shared package ctrl_pkg holds:
  - Encodings of result_src: RES_ALU = 00, RES_MEM = 01, RES_PC4 = 10.
  - ALUCTRL_W and RD_W.
  - A packed struct type for the E-stage control bundle, so the controller and this block share one definition.
- One sub-module, ctrl_stage_reg: a generic width-parameterised register with an async active-low clear and a synchronous clear (bubble) input. Instantiate it three times, tying the synchronous clear to 0 for M and W.

Test Plan:
- Reset mid-stream: drive a valid add for 3 cycles, then pulse rst_n low between edges -> all outputs read 0 before the next edge and instret = 0.
- Single R-type (valid_d = 1, reg_write_d = 1, result_src_d = 00, alu_control_d = 000, rd_d = 5) at edge 0:
  - E outputs match after edge 0.
  - rd_m = 5 after edge 1.
  - rd_w = 5 with valid_w = 1 after edge 2.
  - instret = 1 after edge 3.
- Load followed by flush_e = 1 for one cycle (load-use bubble):
  - The flushed slot shows all-zero controls in E, M and W on successive cycles.
  - instret counts only 2 for the load plus the next instruction.
- beq in E (branch_e = 1): zero_e = 1 -> pc_src_e = 1; zero_e = 0 -> pc_src_e = 0; flipping zero_e within the cycle changes pc_src_e combinationally.
- jal (jump_d = 1, result_src_d = 10, rd_d = 1) -> pc_src_e = 1 independent of zero_e, and result_src_w = 10 with rd_w = 1 two edges later.
- CNT_W = 4 build: stream 17 valid instructions -> instret reads 15, wraps to 0, then reads 1. No other output is affected.
